pwm_from_counter: RTL and testbench
===================================

Name: pwm_from_counter

Overview:
- Downstream consumer of the free-running up counter. Takes the counter's count value and produces a PWM waveform with a programmable duty cycle.
- A new duty value is loaded through a valid/ready handshake into a shadow register. It is applied only at a period boundary, i.e. when the counter wraps from all-ones to 0, so no PWM period is ever truncated.
- Sits between the counter and the output/driver logic.

Parameters:
- BITS, 4, width of the incoming count and of the duty value; PWM period = 2^BITS clk cycles.

Ports:
- clk  in  1  system clock; the same clock that drives the up counter.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- cnt_in  in  BITS  count value from the up counter.
- en  in  1  enable; 0 forces IDLE.
- duty_in  in  BITS  requested duty, in counts per period.
- duty_valid  in  1  duty_in is valid this cycle.
- duty_ready  out  1  shadow register free; a transfer occurs when valid && ready at a rising clk.
- pwm_out  out  1  registered PWM output.
- period_tick  out  1  one-cycle pulse, registered, on each boundary seen in ARM or RUN.
- duty_active  out  BITS  duty value in force for the current period.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - state = IDLE
  - pwm_out = 0, period_tick = 0
  - duty_active = 0, shadow = 0, pending = 0
  - duty_ready = 1
  - prev_cnt = 0
- Reset has the same effect mid-operation; an in-flight shadow value is discarded.
- prev_cnt is a register holding the previous cnt_in, updated every cycle regardless of state.
- boundary = (cnt_in == 0) && (prev_cnt == 2^BITS-1). It is combinational.
  - A count dropping to 0 from any other value (e.g. counter reset mid-run) is NOT a boundary.
  - A count held at 0 is not a boundary either.
- Handshake:
  - duty_ready = !pending.
  - On accept: shadow <= duty_in, pending <= 1.
  - duty_in is ignored while duty_ready = 0, and the handshake works in every state, including IDLE.
- Apply rule: on a boundary in ARM or RUN with pending = 1, duty_active <= shadow and pending <= 0.
  - If an accept and a boundary happen in the same cycle, pending was 0 before the edge. The new value therefore goes to shadow and is applied at the NEXT boundary.
  - In IDLE, boundaries apply nothing.
- FSM transitions:
  - IDLE -> ARM when en = 1.
  - ARM -> RUN on boundary.
  - RUN stays in RUN while en = 1.
  - Any state -> IDLE in the cycle after en = 0; en is sampled at the edge.
- pwm_out:
  - IDLE or ARM: pwm_out <= 0.
  - In the cycle of the ARM -> RUN boundary and in every RUN cycle: pwm_out <= (cnt_in < D). D is the shadow value if a boundary apply occurs this cycle, otherwise duty_active.
  - Latency is 1 clk from cnt_in to pwm_out.
- Duty limits:
  - duty = 0 gives constant 0.
  - duty = 2^BITS-1 gives high for 2^BITS-1 of 2^BITS cycles (100% is not reachable).
  - The comparison is unsigned and BITS wide, with no overflow.
- period_tick <= boundary && (state is ARM or RUN); it is high for exactly one cycle.
- Leaving RUN (en = 0): pwm_out is 0 from the following edge. duty_active and pending are retained, and so are shadow and the handshake state.

Decomposition:
- Package pwm_from_counter_pkg holds:
  - state enum {IDLE, ARM, RUN}, 2 bits;
  - default BITS = 4;
  - localparam function CNT_MAX(BITS) = 2^BITS-1.
- One natural sub-module: cnt_wrap_detect. It holds the prev_cnt register and the boundary compare, parameter BITS, ports clk, reset, cnt_in, boundary. It is reused by later counter consumers.

Test Plan:
- Basic run: BITS = 4, reset 5 cycles, en = 1, load duty 4 before the first wrap -> ARM until cnt goes 15->0, then pwm_out high exactly 4 clk per 16. period_tick pulses every 16 clk.
- Limits: duty 0 -> pwm_out stays 0 for 3 periods; duty 15 -> high 15/16 cycles per period.
- Boundary load: duty 4 active. Present duty 10 with valid in the exact boundary cycle -> accepted; the following period is still 4 and the period after is 10. A second valid while ready = 0 is ignored and held off until the apply.
- Non-wrap zero: counter reset forces cnt 9->0 mid-period -> no period_tick, duty unchanged, pwm_out follows cnt < duty.
- en drop: deassert en mid-high -> pwm_out 0 next edge, state IDLE. Re-enable -> ARM, no output until the next 15->0 wrap.
- Sync reset mid-run with pending = 1 -> next cycle: duty_active = 0, duty_ready = 1, pwm_out = 0, no period_tick.

Source files
------------

// File: rtl/pwm_from_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_from_counter_pkg
//  Description : Shared types and constants for the PWM-from-counter block
//                and its wrap detector: FSM state encoding, default count
//                width and the all-ones count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_from_counter_pkg;

    // Default width of the incoming count and of the duty value.
    localparam int DEFAULT_BITS = 4;

    // FSM state encoding. Explicit 2-bit constants keep the encoding stable
    // for downstream tools that inspect the raw state register.
    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t ARM  = 2'd1;
    localparam state_t RUN  = 2'd2;

    // Largest value a BITS-wide counter reaches before wrapping to zero.
    function automatic int unsigned CNT_MAX(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

endpackage : pwm_from_counter_pkg
`default_nettype wire

// File: rtl/pwm_from_counter_cnt_wrap_detect.sv
`default_nettype none
// ============================================================================
//  Module      : cnt_wrap_detect
//  Description : Detects the wrap of a free-running up counter, i.e. the
//                cycle in which the count reads zero and the previous count
//                was all-ones. A count forced to zero from any other value,
//                or a count held at zero, is not reported.
//
//  Ports       : clk      - system clock (same clock as the counter)
//                reset    - synchronous, active-high reset
//                cnt_in   - count value from the up counter
//                boundary - combinational wrap indication for this cycle
//
//  Revision    : 1.0 - initial release
// ============================================================================
module cnt_wrap_detect
    import pwm_from_counter_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] cnt_in,
    output logic            boundary
);

    localparam logic [BITS-1:0] C_CNT_MAX = BITS'(CNT_MAX(BITS));

    // Previous count sample, updated every cycle independent of any consumer
    // state so the wrap can be recognised even right after enabling.
    logic [BITS-1:0] r_prev_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_cnt <= '0;
        end else begin
            r_prev_cnt <= cnt_in;
        end
    end

    // Requiring the all-ones predecessor rejects mid-period counter resets
    // and a counter that is stalled at zero.
    assign boundary = (cnt_in == '0) && (r_prev_cnt == C_CNT_MAX);

endmodule : cnt_wrap_detect
`default_nettype wire

// File: rtl/pwm_from_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_from_counter
//  Description : Produces a PWM waveform from the count of a free-running up
//                counter. A new duty value is accepted through a valid/ready
//                handshake into a shadow register and only put in force at a
//                counter wrap, so no PWM period is ever truncated.
//
//  Ports       : clk         - system clock (same clock as the up counter)
//                reset       - synchronous, active-high reset
//                cnt_in      - count value from the up counter
//                en          - enable; low returns the block to IDLE
//                duty_in     - requested duty in counts per period
//                duty_valid  - duty_in is valid this cycle
//                duty_ready  - shadow register free (transfer on valid&ready)
//                pwm_out     - registered PWM output
//                period_tick - one-cycle pulse on each wrap seen in ARM/RUN
//                duty_active - duty value in force for the current period
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_from_counter
    import pwm_from_counter_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [BITS-1:0] cnt_in,
    input  logic            en,
    input  logic [BITS-1:0] duty_in,
    input  logic            duty_valid,
    output logic            duty_ready,
    output logic            pwm_out,
    output logic            period_tick,
    output logic [BITS-1:0] duty_active
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t          r_state;
    logic [BITS-1:0] r_shadow;
    logic            r_pending;
    logic [BITS-1:0] r_duty_active;
    logic            r_pwm;
    logic            r_period_tick;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic            w_boundary;
    logic            w_live;
    logic            w_accept;
    logic            w_apply;
    logic            w_run_cycle;
    logic [BITS-1:0] w_duty_eff;
    state_t          w_state_nxt;

    cnt_wrap_detect #(
        .BITS     (BITS)
    ) u_cnt_wrap_detect (
        .clk      (clk),
        .reset    (reset),
        .cnt_in   (cnt_in),
        .boundary (w_boundary)
    );

    // ARM and RUN are the states that observe period boundaries.
    assign w_live     = (r_state == ARM) || (r_state == RUN);

    // The shadow is free whenever no value is waiting to be applied; the
    // handshake is live in every state, including IDLE.
    assign duty_ready = !r_pending;
    assign w_accept   = duty_valid && !r_pending;

    // A waiting value is applied on a boundary. An accept in the same cycle
    // is impossible here (it needs pending low), so a value presented in the
    // boundary cycle lands in the shadow and is applied one period later.
    assign w_apply    = w_boundary && w_live && r_pending;

    // The compare for the first cycle of a new period must already use the
    // value being applied in that cycle.
    assign w_duty_eff = w_apply ? r_shadow : r_duty_active;

    // The output is driven in every RUN cycle and in the ARM->RUN wrap cycle;
    // a low enable at the edge forces the output low from that edge on.
    assign w_run_cycle = en && ((r_state == RUN) ||
                                ((r_state == ARM) && w_boundary));

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (!en) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = ARM;
                ARM:     w_state_nxt = w_boundary ? RUN : ARM;
                RUN:     w_state_nxt = RUN;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_pwm         <= 1'b0;
            r_period_tick <= 1'b0;
            r_duty_active <= '0;
            r_shadow      <= '0;
            r_pending     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_period_tick <= w_boundary && w_live;
            // Unsigned BITS-wide compare: duty 0 never goes high and the
            // all-ones duty stays high for all but the last count.
            r_pwm         <= w_run_cycle && (cnt_in < w_duty_eff);

            if (w_apply) begin
                r_duty_active <= r_shadow;
                r_pending     <= 1'b0;
            end else if (w_accept) begin
                r_shadow      <= duty_in;
                r_pending     <= 1'b1;
            end
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_period_tick;
    assign duty_active = r_duty_active;

endmodule : pwm_from_counter
`default_nettype wire

// File: tb/tb_pwm_from_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_from_counter
//  Description : Self-checking bench for pwm_from_counter (BITS = 4). A
//                behavioural reference model predicts every output for each
//                clock edge; the prediction is queued when the stimulus is
//                driven and compared after the edge. Scenario tasks add
//                period-level checks (high counts and ticks per period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_from_counter;

    localparam int BITS = 4;

    logic            clk;
    logic            reset;
    logic [BITS-1:0] cnt_in;
    logic            en;
    logic [BITS-1:0] duty_in;
    logic            duty_valid;
    logic            duty_ready;
    logic            pwm_out;
    logic            period_tick;
    logic [BITS-1:0] duty_active;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic            pwm;
        logic            tick;
        logic [BITS-1:0] duty;
        logic            ready;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state (0 idle, 1 arm, 2 run)
    int        m_st    = 0;
    bit [3:0]  m_prev  = 0;
    bit [3:0]  m_duty  = 0;
    bit [3:0]  m_sh    = 0;
    bit        m_pend  = 0;

    pwm_from_counter #(.BITS(BITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .cnt_in      (cnt_in),
        .en          (en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .duty_active (duty_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predict the outputs after the coming edge from the present inputs,
    // queue the prediction, take the edge, then compare.
    task automatic sb_cycle();
        exp_t     e;
        exp_t     got;
        bit       bnd;
        bit       live;
        bit       appl;
        bit       running;
        bit [3:0] d;
        bnd = (cnt_in == 4'd0) && (m_prev == 4'd15);
        if (reset) begin
            m_st = 0; m_prev = 0; m_duty = 0; m_sh = 0; m_pend = 0;
            e = '{pwm: 1'b0, tick: 1'b0, duty: 4'd0, ready: 1'b1};
        end else begin
            live    = (m_st != 0);
            appl    = bnd && live && m_pend;
            d       = appl ? m_sh : m_duty;
            running = en && ((m_st == 2) || (m_st == 1 && bnd));
            e.pwm   = running && (cnt_in < d);
            e.tick  = bnd && live;
            if (appl) begin
                m_duty = m_sh;
                m_pend = 0;
            end else if (duty_valid && !m_pend) begin
                m_sh   = duty_in;
                m_pend = 1;
            end
            if (!en)            m_st = 0;
            else if (m_st == 0) m_st = 1;
            else if (m_st == 1) m_st = bnd ? 2 : 1;
            m_prev  = cnt_in;
            e.duty  = m_duty;
            e.ready = !m_pend;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        checks++;
        if (pwm_out !== got.pwm) begin
            errors++;
            $display("FAIL pwm_out @%0t: got %b, expected %b", $time, pwm_out, got.pwm);
        end
        checks++;
        if (period_tick !== got.tick) begin
            errors++;
            $display("FAIL period_tick @%0t: got %b, expected %b", $time, period_tick, got.tick);
        end
        checks++;
        if (duty_active !== got.duty) begin
            errors++;
            $display("FAIL duty_active @%0t: got %0d, expected %0d", $time, duty_active, got.duty);
        end
        checks++;
        if (duty_ready !== got.ready) begin
            errors++;
            $display("FAIL duty_ready @%0t: got %b, expected %b", $time, duty_ready, got.ready);
        end
    endtask

    // One clock with the free-running counter advancing afterwards.
    task automatic step();
        sb_cycle();
        cnt_in = cnt_in + 4'd1;
    endtask

    // Advance until the next input count is zero (bounded to one period).
    task automatic step_to_zero(output int hi, output int tk);
        hi = 0; tk = 0;
        for (int i = 0; i < 16 && cnt_in != 4'd0; i++) begin
            step();
            hi += int'(pwm_out);
            tk += int'(period_tick);
        end
    endtask

    // One full period starting at count 0, optionally presenting a new duty
    // in the first (boundary) cycle.
    task automatic run_period(input bit load, input logic [3:0] d,
                              output int hi, output int tk);
        hi = 0; tk = 0;
        for (int i = 0; i < 16; i++) begin
            duty_valid = load && (i == 0);
            duty_in    = d;
            step();
            hi += int'(pwm_out);
            tk += int'(period_tick);
        end
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; cnt_in = 4'd0; duty_in = 4'd0; duty_valid = 1'b0;
        repeat (5) step();
        checks++;
        if (pwm_out !== 1'b0 || period_tick !== 1'b0 || duty_active !== 4'd0 || duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got pwm=%b tick=%b duty=%0d ready=%b, expected 0 0 0 1",
                     pwm_out, period_tick, duty_active, duty_ready);
        end
    endtask

    task automatic test_basic();
        int hi, tk;
        reset = 1'b0; en = 1'b1;
        duty_in = 4'd4; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        step_to_zero(hi, tk);
        checks++;
        if (hi != 0 || tk != 0) begin
            errors++;
            $display("FAIL basic_arm_quiet: got hi=%0d ticks=%0d, expected 0 0", hi, tk);
        end
        for (int p = 0; p < 2; p++) begin
            run_period(1'b0, 4'd0, hi, tk);
            checks++;
            if (hi != 4 || tk != 1) begin
                errors++;
                $display("FAIL basic_period%0d: got hi=%0d ticks=%0d, expected 4 1", p, hi, tk);
            end
        end
    endtask

    task automatic test_limits();
        int hi, tk;
        run_period(1'b1, 4'd0, hi, tk);
        checks++;
        if (hi != 4) begin
            errors++;
            $display("FAIL limits_old_duty: got hi=%0d, expected 4", hi);
        end
        for (int p = 0; p < 3; p++) begin
            run_period(1'b0, 4'd0, hi, tk);
            checks++;
            if (hi != 0 || tk != 1) begin
                errors++;
                $display("FAIL limits_duty0_p%0d: got hi=%0d ticks=%0d, expected 0 1", p, hi, tk);
            end
        end
        run_period(1'b1, 4'd15, hi, tk);
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 15 || tk != 1) begin
            errors++;
            $display("FAIL limits_duty15: got hi=%0d ticks=%0d, expected 15 1", hi, tk);
        end
    endtask

    task automatic test_boundary_load();
        int hi, tk;
        run_period(1'b1, 4'd4, hi, tk);
        run_period(1'b0, 4'd0, hi, tk);
        // Duty 4 in force; present 10 exactly in the boundary cycle.
        run_period(1'b1, 4'd10, hi, tk);
        checks++;
        if (hi != 4 || duty_active !== 4'd4) begin
            errors++;
            $display("FAIL bload_same_period: got hi=%0d duty=%0d, expected 4 4", hi, duty_active);
        end
        // Offer 7 while the shadow is still occupied.
        duty_in = 4'd7; duty_valid = 1'b1;
        step();
        hi = int'(pwm_out);
        checks++;
        if (duty_active !== 4'd10 || duty_ready !== 1'b1) begin
            errors++;
            $display("FAIL bload_apply: got duty=%0d ready=%b, expected 10 1", duty_active, duty_ready);
        end
        step();
        hi += int'(pwm_out);
        duty_valid = 1'b0;
        checks++;
        if (duty_ready !== 1'b0) begin
            errors++;
            $display("FAIL bload_held_accept: got ready=%b, expected 0", duty_ready);
        end
        for (int i = 0; i < 14; i++) begin
            step();
            hi += int'(pwm_out);
        end
        checks++;
        if (hi != 10) begin
            errors++;
            $display("FAIL bload_next_period: got hi=%0d, expected 10", hi);
        end
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 7 || tk != 1) begin
            errors++;
            $display("FAIL bload_held_value: got hi=%0d ticks=%0d, expected 7 1", hi, tk);
        end
    endtask

    task automatic test_nonwrap_zero();
        int hi, tk;
        repeat (10) step();
        cnt_in = 4'd0;  // counter reset mid-period (9 -> 0)
        step();
        checks++;
        if (period_tick !== 1'b0 || pwm_out !== 1'b1 || duty_active !== 4'd7) begin
            errors++;
            $display("FAIL nonwrap_zero: got tick=%b pwm=%b duty=%0d, expected 0 1 7",
                     period_tick, pwm_out, duty_active);
        end
        step_to_zero(hi, tk);
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 7 || tk != 1) begin
            errors++;
            $display("FAIL nonwrap_recover: got hi=%0d ticks=%0d, expected 7 1", hi, tk);
        end
    endtask

    task automatic test_en_drop();
        int hi, tk;
        repeat (3) step();
        checks++;
        if (pwm_out !== 1'b1) begin
            errors++;
            $display("FAIL en_drop_midhigh: got pwm=%b, expected 1", pwm_out);
        end
        en = 1'b0;
        step();
        checks++;
        if (pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_low: got pwm=%b, expected 0", pwm_out);
        end
        step_to_zero(hi, tk);
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 0 || tk != 0) begin
            errors++;
            $display("FAIL en_idle_period: got hi=%0d ticks=%0d, expected 0 0", hi, tk);
        end
        en = 1'b1;
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 0 || tk != 0) begin
            errors++;
            $display("FAIL en_rearm_quiet: got hi=%0d ticks=%0d, expected 0 0", hi, tk);
        end
        run_period(1'b0, 4'd0, hi, tk);
        checks++;
        if (hi != 7 || tk != 1 || duty_active !== 4'd7) begin
            errors++;
            $display("FAIL en_resume: got hi=%0d ticks=%0d duty=%0d, expected 7 1 7", hi, tk, duty_active);
        end
    endtask

    task automatic test_reset_mid();
        int hi, tk;
        duty_in = 4'd3; duty_valid = 1'b1;
        step();
        duty_valid = 1'b0;
        step_to_zero(hi, tk);
        reset = 1'b1;  // asserted exactly in a wrap cycle with a value pending
        step();
        reset = 1'b0;
        checks++;
        if (duty_active !== 4'd0 || duty_ready !== 1'b1 || pwm_out !== 1'b0 || period_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got duty=%0d ready=%b pwm=%b tick=%b, expected 0 1 0 0",
                     duty_active, duty_ready, pwm_out, period_tick);
        end
        repeat (4) step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_boundary_load();
        test_nonwrap_zero();
        test_en_drop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_from_counter
`default_nettype wire
